// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared digit codes and active-low 7-segment patterns.
// Pattern bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_scan_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] pattern_t;

  localparam digit_t ERR_CODE = 4'hF;

  localparam pattern_t SEG_0    = 7'b1000000;
  localparam pattern_t SEG_1    = 7'b1111001;
  localparam pattern_t SEG_2    = 7'b0100100;
  localparam pattern_t SEG_3    = 7'b0110000;
  localparam pattern_t SEG_4    = 7'b0011001;
  localparam pattern_t SEG_5    = 7'b0010010;
  localparam pattern_t SEG_6    = 7'b0000010;
  localparam pattern_t SEG_7    = 7'b1111000;
  localparam pattern_t SEG_8    = 7'b0000000;
  localparam pattern_t SEG_9    = 7'b0010000;
  localparam pattern_t SEG_DASH = 7'b0111111;
  localparam pattern_t SEG_OFF  = 7'b1111111;

  // Any input above 9, in any of its 32 bits,
  // collapses to the error code.
  function automatic digit_t to_digit(
    input logic [31:0] v
  );
    if (v > 32'd9) return ERR_CODE;
    return v[3:0];
  endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// seg7_decode: combinational 4-bit digit code to active-low pattern.
// Ports: code (in, 4b), pattern (out, 7b {g,f,e,d,c,b,a}).
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Codes 10..14 never get stored; show them as
  // a dash like the error code.
  always_comb begin
    pattern = SEG_DASH;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-seg scanner with lz blanking.
// Ports: clk, rst, units..thousands, load, blank_lz -> an, seg, busy_scan.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] units,
  input  logic [31:0] tens,
  input  logic [31:0] hundreds,
  input  logic [31:0] thousands,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        busy_scan
);

  localparam int CW =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(REFRESH_DIV - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  digit_t [3:0]     dig_q, dig_d;
  logic [3:0]       an_q, an_d;
  pattern_t         seg_q, seg_d;
  logic             wrap;
  logic [3:0]       blank;
  digit_t           cur;
  pattern_t         cur_pat;

  assign wrap = (cnt_q == LAST);
  assign cur  = dig_q[idx_q];

  seg7_decode u_dec (
    .code    (cur),
    .pattern (cur_pat)
  );

  // Blanking ripples down from the top digit;
  // an error digit is nonzero so it breaks the chain.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = blank_lz && (dig_q[3] == 4'd0);
    blank[2] = blank[3] && (dig_q[2] == 4'd0);
    blank[1] = blank[2] && (dig_q[1] == 4'd0);
  end

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    dig_d = dig_q;
    if (load) begin
      dig_d[0] = to_digit(units);
      dig_d[1] = to_digit(tens);
      dig_d[2] = to_digit(hundreds);
      dig_d[3] = to_digit(thousands);
    end
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    if (!blank[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = cur_pat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      dig_q <= '0;
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dig_q <= dig_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign busy_scan = wrap;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench with a time-based reference model.
// Drives REFRESH_DIV=4; checks every cycle plus literal spot checks.
module tb_seg_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] units, tens, hundreds, thousands;
  logic        load, blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busy_scan;

  int vectors = 0;
  int miscompares = 0;

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .units     (units),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .load      (load),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .busy_scan (busy_scan)
  );

  always #5 clk = ~clk;

  // Reference model: slot number comes from cycles since reset.
  int         t;
  int         mdig [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  bit         mvalid = 0;

  function automatic logic [6:0] pat(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100,
            7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000,
            7'b0010000};
    if (d > 9) return 7'b0111111;
    return tbl[d];
  endfunction

  function automatic int val(input logic [31:0] v);
    if (v > 32'd9) return 15;
    return int'(v);
  endfunction

  always @(posedge clk) begin
    int  s;
    bit  blk;
    if (rst) begin
      t       = 0;
      mdig    = '{0, 0, 0, 0};
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      mvalid  = 1;
    end else if (mvalid) begin
      s   = (t / DIV) % 4;
      blk = blank_lz && (s > 0);
      for (int j = s; j < 4; j++)
        if (mdig[j] != 0) blk = 0;
      if (blk) begin
        exp_an  = 4'b1111;
        exp_seg = 7'b1111111;
      end else begin
        exp_an  = 4'b1111 & ~(4'b0001 << s);
        exp_seg = pat(mdig[s]);
      end
      if (load) begin
        mdig[0] = val(units);
        mdig[1] = val(tens);
        mdig[2] = val(hundreds);
        mdig[3] = val(thousands);
      end
      t = t + 1;
    end
  end

  always @(negedge clk) begin
    logic eb;
    if (mvalid) begin
      eb = ((t % DIV) == DIV - 1);
      vectors++;
      if (an !== exp_an || seg !== exp_seg || busy_scan !== eb) begin
        miscompares++;
        $display("FAIL model t=%0d: an=%b seg=%b busy=%b, want an=%b seg=%b busy=%b",
                 t, an, seg, busy_scan, exp_an, exp_seg, eb);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name,
                     input logic [3:0] a,
                     input logic [6:0] s);
    vectors++;
    if (an !== a || seg !== s) begin
      miscompares++;
      $display("FAIL %s: an=%b seg=%b, want an=%b seg=%b",
               name, an, seg, a, s);
    end
  endtask

  task automatic chk_busy(input string name, input logic b);
    vectors++;
    if (busy_scan !== b) begin
      miscompares++;
      $display("FAIL %s: busy_scan=%b, want %b",
               name, busy_scan, b);
    end
  endtask

  task automatic put(input logic [31:0] u, input logic [31:0] te,
                     input logic [31:0] h, input logic [31:0] th);
    units     = u;
    tens      = te;
    hundreds  = h;
    thousands = th;
    load      = 1'b1;
  endtask

  // Two reset edges; returns at the negedge where rst drops (cnt=0).
  task automatic do_reset;
    rst  = 1'b1;
    load = 1'b0;
    tick(2);
    chk("reset_out", 4'b1111, 7'b1111111);
    chk_busy("reset_busy", 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0;
    units = '0; tens = '0; hundreds = '0; thousands = '0;
    tick(1);

    // Reset and first busy_scan timing.
    do_reset();
    chk_busy("busy_c0", 1'b0); tick(1);
    chk_busy("busy_c1", 1'b0); tick(1);
    chk_busy("busy_c2", 1'b0); tick(1);
    chk_busy("busy_c3", 1'b1); tick(1);
    chk_busy("busy_c4", 1'b0);

    // Plain scan of 4,3,2,1.
    tick(1);
    do_reset();
    put(1, 2, 3, 4); tick(1);
    load = 1'b0; tick(1);
    chk("scan0", 4'b1110, 7'b1111001); tick(4);
    chk("scan1", 4'b1101, 7'b0100100); tick(4);
    chk("scan2", 4'b1011, 7'b0110000); tick(4);
    chk("scan3", 4'b0111, 7'b0011001); tick(4);
    chk("scan0w", 4'b1110, 7'b1111001);

    // Leading-zero blanking of 0007.
    tick(1);
    do_reset();
    blank_lz = 1'b1;
    put(7, 0, 0, 0); tick(1);
    load = 1'b0; tick(1);
    chk("blk0", 4'b1110, 7'b1111000); tick(4);
    chk("blk1", 4'b1111, 7'b1111111); tick(4);
    chk("blk2", 4'b1111, 7'b1111111); tick(4);
    chk("blk3", 4'b1111, 7'b1111111);
    blank_lz = 1'b0; tick(1);
    chk("noblk3", 4'b0111, 7'b1000000);

    // Error digits: high-bit units and thousands=10.
    tick(1);
    do_reset();
    blank_lz = 1'b1;
    put(32'h8000_0001, 0, 0, 10); tick(1);
    load = 1'b0; tick(1);
    chk("err0", 4'b1110, 7'b0111111); tick(4);
    chk("err1", 4'b1101, 7'b1000000); tick(8);
    chk("err3", 4'b0111, 7'b0111111);
    blank_lz = 1'b0;

    // Load coinciding with busy_scan.
    tick(1);
    do_reset();
    put(1, 2, 3, 4); tick(1);
    load = 1'b0; tick(2);
    chk_busy("coin_busy", 1'b1);
    put(5, 5, 5, 5); tick(1);
    load = 1'b0;
    chk("coin_old", 4'b1110, 7'b1111001); tick(1);
    chk("coin_new", 4'b1101, 7'b0010010);

    // Reset in the middle of slot 2.
    tick(1);
    do_reset();
    put(1, 2, 3, 4); tick(1);
    load = 1'b0; tick(9);
    chk("mid_pre", 4'b1011, 7'b0110000);
    rst = 1'b1; tick(1);
    chk("mid_rst", 4'b1111, 7'b1111111);
    chk_busy("mid_busy", 1'b0);
    rst = 1'b0; tick(2);
    chk("mid_s0", 4'b1110, 7'b1000000); tick(1);
    chk_busy("mid_wrap", 1'b1); tick(3);
    chk("mid_s1", 4'b1101, 7'b1000000);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
